// File: rtl/pipeline_stall_ctrl_pkg.sv
// rtl/pipeline_stall_ctrl_pkg.sv - shared types and helpers for the pipeline stall controller
package pipeline_stall_ctrl_pkg;

  localparam int DIV_CYCLES_DEF = 32;

  typedef enum logic [1:0] {
    RUN,
    DIV_WAIT,
    REDIR_PEND
  } state_e;

  // Winning stall source, also handy on a debug probe.
  typedef enum logic [2:0] {
    CAUSE_NONE,
    CAUSE_HAZARD,
    CAUSE_ICACHE,
    CAUSE_DIV,
    CAUSE_DCACHE,
    CAUSE_REDIR
  } stall_cause_e;

  function automatic stall_cause_e resolve_cause(
    input logic redir,
    input logic dcache,
    input logic div_busy,
    input logic icache,
    input logic hazard
  );
    if (redir)         return CAUSE_REDIR;
    else if (dcache)   return CAUSE_DCACHE;
    else if (div_busy) return CAUSE_DIV;
    else if (icache)   return CAUSE_ICACHE;
    else if (hazard)   return CAUSE_HAZARD;
    else               return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_div.sv
// rtl/pipeline_stall_ctrl_div.sv - divider occupancy counter with freeze, abort and done pulse
module div_occupancy_counter
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_en_i,
  input  logic abort_i,
  output logic busy_o,
  output logic last_o,
  output logic done_o
);

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (abort_i) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      // Loads while busy are dropped; the count only moves when not frozen.
      if (dec_en_i) begin
        cnt_d  = cnt_q - CNT_ONE;
        done_d = (cnt_q == CNT_ONE);
      end
    end else if (load_i) begin
      cnt_d = CNT_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign last_o = (cnt_q == CNT_ONE);
  assign done_o = done_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - resolves stall/flush requests into per-stage enables and bubbles
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int PC_W       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stcl_lw,
  input  logic            stcl_jmp,
  input  logic            icache_stall,
  input  logic            dcache_stall,
  input  logic            div_start,
  input  logic            exc_req,
  input  logic [PC_W-1:0] exc_pc,
  output logic            pc_en,
  output logic            if_id_en,
  output logic            id_exe_en,
  output logic            exe_mem_en,
  output logic            mem_wb_en,
  output logic            if_id_flush,
  output logic            id_exe_flush,
  output logic            exe_mem_flush,
  output logic            mem_wb_flush,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_target,
  output logic            div_busy,
  output logic            div_done,
  output logic [31:0]     stall_cycles
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic [31:0]     stall_q;
  logic            redirect;
  logic            cnt_busy, cnt_last, cnt_done;
  stall_cause_e    cause;

  assign redirect = exc_req | (state_q == REDIR_PEND);

  div_occupancy_counter #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (div_start & ~redirect),
    .dec_en_i (~dcache_stall),
    .abort_i  (redirect),
    .busy_o   (cnt_busy),
    .last_o   (cnt_last),
    .done_o   (cnt_done)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = exc_req ? exc_pc : tgt_q;
    if (exc_req) begin
      // The redirect must stay asserted until IF can actually accept it.
      state_d = icache_stall ? REDIR_PEND : RUN;
    end else begin
      case (state_q)
        RUN:        if (div_start) state_d = DIV_WAIT;
        DIV_WAIT:   if (cnt_last && !dcache_stall) state_d = RUN;
        REDIR_PEND: if (!icache_stall) state_d = RUN;
        default:    state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  assign cause     = resolve_cause(redirect, dcache_stall, cnt_busy, icache_stall, stcl_lw | stcl_jmp);
  assign pc_target = exc_req ? exc_pc : tgt_q;

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_exe_en     = 1'b1;
    exe_mem_en    = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_flush  = 1'b0;
    exe_mem_flush = 1'b0;
    mem_wb_flush  = 1'b0;
    pc_load       = 1'b0;
    case (cause)
      CAUSE_REDIR: begin
        if_id_flush   = 1'b1;
        id_exe_flush  = 1'b1;
        exe_mem_flush = 1'b1;
        pc_load       = 1'b1;
      end
      CAUSE_DCACHE: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_exe_en    = 1'b0;
        exe_mem_en   = 1'b0;
        mem_wb_flush = 1'b1;
      end
      CAUSE_DIV: begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_exe_en     = 1'b0;
        exe_mem_flush = 1'b1;
      end
      CAUSE_ICACHE: begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
      end
      CAUSE_HAZARD: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_exe_flush = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      id_exe_en     = 1'b1;
      exe_mem_en    = 1'b1;
      mem_wb_en     = 1'b1;
      if_id_flush   = 1'b1;
      id_exe_flush  = 1'b1;
      exe_mem_flush = 1'b1;
      mem_wb_flush  = 1'b1;
      pc_load       = 1'b0;
    end
  end

  assign div_busy = rst_n & cnt_busy;
  assign div_done = rst_n & cnt_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (!pc_en && !pc_load && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed self-checking bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

  localparam int PC_W = 32;

  // {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en, if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush, pc_load}
  localparam logic [9:0] C_NONE   = 10'b11111_0000_0;
  localparam logic [9:0] C_REDIR  = 10'b11111_1110_1;
  localparam logic [9:0] C_DCACHE = 10'b00001_0001_0;
  localparam logic [9:0] C_DIV    = 10'b00011_0010_0;
  localparam logic [9:0] C_ICACHE = 10'b01111_1000_0;
  localparam logic [9:0] C_HAZARD = 10'b00111_0100_0;
  localparam logic [9:0] C_RST    = 10'b11111_1111_0;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stcl_lw, stcl_jmp, icache_stall, dcache_stall, div_start, exc_req;
  logic [PC_W-1:0] exc_pc;
  logic            pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en;
  logic            if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush;
  logic            pc_load, div_busy, div_done;
  logic [PC_W-1:0] pc_target;
  logic [31:0]     stall_cycles;
  logic [9:0]      ctl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.DIV_CYCLES(32), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .stcl_lw(stcl_lw), .stcl_jmp(stcl_jmp),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .div_start(div_start), .exc_req(exc_req), .exc_pc(exc_pc),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_exe_en(id_exe_en),
    .exe_mem_en(exe_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
    .exe_mem_flush(exe_mem_flush), .mem_wb_flush(mem_wb_flush),
    .pc_load(pc_load), .pc_target(pc_target),
    .div_busy(div_busy), .div_done(div_done), .stall_cycles(stall_cycles)
  );

  assign ctl = {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
                if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush, pc_load};

  always @(posedge clk)
    assert (!(rst_n && div_start && div_busy)) else $error("protocol: div_start while div_busy");

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    stcl_lw = 0; stcl_jmp = 0; icache_stall = 0; dcache_stall = 0;
    div_start = 0; exc_req = 0; exc_pc = '0;
  endtask

  task automatic run_div(input int dc_lo, input int dc_hi, input int exc_at,
                         output int busy_cnt, output int done_cnt, output int done_at, output int bad);
    busy_cnt = 0; done_cnt = 0; done_at = -1; bad = 0;
    clear_inputs();
    div_start = 1;
    settle();
    check("div_start_cycle_ctl", 32'(ctl), 32'(C_NONE));
    for (int k = 1; k <= 45; k++) begin
      tick();
      clear_inputs();
      dcache_stall = (k >= dc_lo) && (k <= dc_hi);
      if (k == exc_at) begin
        exc_req = 1;
        exc_pc  = 32'h8000_0180;
      end
      settle();
      if (div_busy) busy_cnt++;
      if (div_done) begin done_cnt++; done_at = k; end
      if (div_busy && !dcache_stall && !exc_req && ctl !== C_DIV) bad++;
      if (k == dc_lo) check("div_dcache_ctl", 32'(ctl), 32'(C_DCACHE));
      if (k == exc_at) begin
        check("div_exc_ctl", 32'(ctl), 32'(C_REDIR));
        check("div_exc_target", pc_target, 32'h8000_0180);
      end
    end
    tick();
    clear_inputs();
  endtask

  initial begin
    int busy_cnt, done_cnt, done_at, bad;
    rst_n = 0;
    clear_inputs();
    settle();
    check("reset_ctl", 32'(ctl), 32'(C_RST));
    check("reset_div_busy", 32'(div_busy), 0);
    check("reset_div_done", 32'(div_done), 0);
    tick();
    settle();
    check("reset_stall_cycles", stall_cycles, 0);
    rst_n = 1;
    settle();
    check("idle_ctl", 32'(ctl), 32'(C_NONE));

    stcl_lw = 1;
    settle();
    check("lw_ctl", 32'(ctl), 32'(C_HAZARD));
    check("lw_stall_before", stall_cycles, 0);
    tick(); clear_inputs(); settle();
    check("lw_stall_after", stall_cycles, 1);
    check("lw_release_ctl", 32'(ctl), 32'(C_NONE));

    stcl_jmp = 1;
    settle();
    check("jmp_ctl", 32'(ctl), 32'(C_HAZARD));
    tick(); clear_inputs();

    icache_stall = 1; stcl_lw = 1;
    settle();
    check("icache_over_hazard_ctl", 32'(ctl), 32'(C_ICACHE));
    tick(); clear_inputs();

    dcache_stall = 1; icache_stall = 1; stcl_lw = 1;
    settle();
    check("dcache_over_all_ctl", 32'(ctl), 32'(C_DCACHE));
    tick(); clear_inputs(); settle();
    check("stall_after_singles", stall_cycles, 4);

    run_div(0, -1, 0, busy_cnt, done_cnt, done_at, bad);
    check("div_busy_cycles", busy_cnt, 31);
    check("div_done_at", done_at, 32);
    check("div_done_count", done_cnt, 1);
    check("div_flush_ctl_bad", bad, 0);
    settle();
    check("stall_after_div", stall_cycles, 35);

    run_div(10, 14, 0, busy_cnt, done_cnt, done_at, bad);
    check("divdc_busy_cycles", busy_cnt, 36);
    check("divdc_done_at", done_at, 37);
    check("divdc_done_count", done_cnt, 1);
    check("divdc_flush_ctl_bad", bad, 0);

    run_div(0, -1, 5, busy_cnt, done_cnt, done_at, bad);
    check("divexc_busy_cycles", busy_cnt, 5);
    check("divexc_done_count", done_cnt, 0);
    settle();
    check("stall_after_divexc", stall_cycles, 75);

    exc_req = 1; exc_pc = 32'hBFC0_0380; icache_stall = 1;
    for (int c = 0; c <= 4; c++) begin
      settle();
      check($sformatf("pend_ctl_c%0d", c), 32'(ctl), (c < 4) ? 32'(C_REDIR) : 32'(C_NONE));
      if (c < 4) check($sformatf("pend_target_c%0d", c), pc_target, 32'hBFC0_0380);
      tick();
      clear_inputs();
      icache_stall = (c < 2);
    end

    exc_req = 1; exc_pc = 32'h0000_1000; icache_stall = 1;
    settle();
    check("ovw_first_target", pc_target, 32'h0000_1000);
    tick(); exc_req = 1; exc_pc = 32'h0000_2000; icache_stall = 1;
    settle();
    tick(); clear_inputs(); icache_stall = 1;
    settle();
    check("ovw_pend_ctl", 32'(ctl), 32'(C_REDIR));
    check("ovw_latched_target", pc_target, 32'h0000_2000);
    tick(); clear_inputs();
    settle();
    check("ovw_last_pend_ctl", 32'(ctl), 32'(C_REDIR));
    tick(); settle();
    check("ovw_back_to_run_ctl", 32'(ctl), 32'(C_NONE));

    exc_req = 1; exc_pc = 32'h0000_3000; div_start = 1;
    settle();
    check("exc_div_same_ctl", 32'(ctl), 32'(C_REDIR));
    tick(); clear_inputs(); settle();
    check("exc_div_same_busy", 32'(div_busy), 0);
    check("exc_div_same_after_ctl", 32'(ctl), 32'(C_NONE));
    check("stall_after_redirects", stall_cycles, 75);

    rst_n = 0; tick(); rst_n = 1;
    stcl_lw = 1;
    for (int i = 0; i < 7; i++) tick();
    clear_inputs();
    div_start = 1;
    tick(); clear_inputs();
    for (int i = 0; i < 3; i++) tick();
    settle();
    check("premid_stall_cycles", stall_cycles, 10);
    check("premid_div_busy", 32'(div_busy), 1);
    rst_n = 0;
    settle();
    check("midreset_ctl", 32'(ctl), 32'(C_RST));
    check("midreset_div_busy", 32'(div_busy), 0);
    tick(); rst_n = 1; settle();
    check("postreset_stall", stall_cycles, 0);
    check("postreset_div_busy", 32'(div_busy), 0);
    check("postreset_ctl", 32'(ctl), 32'(C_NONE));
    done_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick(); settle();
      if (div_done) done_cnt++;
      if (div_busy) busy_cnt++;
    end
    check("postreset_no_done", done_cnt, 0);
    check("postreset_no_busy", busy_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
